// File: rtl/inst_mem_loadable_if.sv
// Load and fetch signal bundle for inst_mem_loadable.
// The master side is the program loader / fetch stage; the slave side is the memory.
interface inst_mem_loadable_if #(
   parameter int INST_W = 10,
   parameter int ADDR_W = 16
);
   logic              LoadStart;
   logic              LoadValid;
   logic              LoadLast;
   logic [INST_W-1:0] LoadData;
   logic              LoadBusy;
   logic              Ready;
   logic [ADDR_W:0]   ProgLen;
   logic              LoadOverflow;
   logic              FetchReq;
   logic [ADDR_W-1:0] InstAddress;
   logic [INST_W-1:0] InstOut;
   logic              InstValid;
   logic              AddrFault;

   modport master (
      output LoadStart, LoadValid, LoadLast, LoadData, FetchReq, InstAddress,
      input  LoadBusy, Ready, ProgLen, LoadOverflow, InstOut, InstValid, AddrFault
   );

   modport slave (
      input  LoadStart, LoadValid, LoadLast, LoadData, FetchReq, InstAddress,
      output LoadBusy, Ready, ProgLen, LoadOverflow, InstOut, InstValid, AddrFault
   );
endinterface

// File: rtl/inst_mem_loadable.sv
// Run-time loadable instruction memory with a one-cycle registered fetch port.
// Fetches at or beyond the loaded program length return the all-zero NOP and flag a fault.
module inst_mem_loadable #(
   parameter int INST_W = 10,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic Clk,
   input  logic ResetN,
   inst_mem_loadable_if.slave bus
);
   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY} state_t;

   state_t            state_q,      state_d;
   logic [ADDR_W:0]   prog_len_q,   prog_len_d;
   logic              overflow_q,   overflow_d;
   logic [INST_W-1:0] inst_out_q,   inst_out_d;
   logic              inst_valid_q, inst_valid_d;
   logic              addr_fault_q, addr_fault_d;

   logic [INST_W-1:0] mem_q [DEPTH];
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   // Low index bits suffice: writes need prog_len < DEPTH, reads need addr < prog_len.
   assign wr_idx = prog_len_q[IDX_W-1:0];
   assign rd_idx = bus.InstAddress[IDX_W-1:0];

   always_comb begin
      state_d      = state_q;
      prog_len_d   = prog_len_q;
      overflow_d   = overflow_q;
      inst_out_d   = inst_out_q;
      inst_valid_d = 1'b0;
      addr_fault_d = 1'b0;
      wr_en        = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            if (bus.LoadStart) begin
               state_d    = ST_LOAD;
               prog_len_d = '0;
               overflow_d = 1'b0;
            end
         end
         ST_LOAD: begin
            // A restart wins over any word or end marker offered alongside it.
            if (bus.LoadStart) begin
               prog_len_d = '0;
               overflow_d = 1'b0;
            end else begin
               if (bus.LoadValid) begin
                  if (prog_len_q < DEPTH_L) begin
                     wr_en      = 1'b1;
                     prog_len_d = prog_len_q + ONE_L;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               if (bus.LoadLast) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (bus.LoadStart) begin
               state_d    = ST_LOAD;
               prog_len_d = '0;
               overflow_d = 1'b0;
            end else if (bus.FetchReq) begin
               inst_valid_d = 1'b1;
               if ({1'b0, bus.InstAddress} < prog_len_q) begin
                  inst_out_d = mem_q[rd_idx];
               end else begin
                  inst_out_d   = '0;
                  addr_fault_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= ST_EMPTY;
         prog_len_q   <= '0;
         overflow_q   <= 1'b0;
         inst_out_q   <= '0;
         inst_valid_q <= 1'b0;
         addr_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prog_len_q   <= prog_len_d;
         overflow_q   <= overflow_d;
         inst_out_q   <= inst_out_d;
         inst_valid_q <= inst_valid_d;
         addr_fault_q <= addr_fault_d;
      end
   end

   // Storage is deliberately left unreset; prog_len gating hides stale words.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= bus.LoadData;
      end
   end

   assign bus.LoadBusy     = (state_q == ST_LOAD);
   assign bus.Ready        = (state_q == ST_READY);
   assign bus.ProgLen      = prog_len_q;
   assign bus.LoadOverflow = overflow_q;
   assign bus.InstOut      = inst_out_q;
   assign bus.InstValid    = inst_valid_q;
   assign bus.AddrFault    = addr_fault_q;
endmodule

// File: tb/tb_inst_mem_loadable.sv
// Bench for inst_mem_loadable: a DEPTH 256 and a DEPTH 4 instance see the same stimulus,
// each checked against its own array/queue reference model.
module tb_inst_mem_loadable;
   localparam int IW = 10;
   localparam int AW = 16;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [IW-1:0] data;
      logic          fault;
   } exp_t;

   logic          Clk = 1'b0;
   logic          ResetN = 1'b0;
   logic          ls = 1'b0, lv = 1'b0, ll = 1'b0, fr = 1'b0;
   logic [IW-1:0] ld = '0;
   logic [AW-1:0] addr = '0;

   always #5 Clk = ~Clk;

   inst_mem_loadable_if #(.INST_W(IW), .ADDR_W(AW)) if_a ();
   inst_mem_loadable_if #(.INST_W(IW), .ADDR_W(AW)) if_b ();

   assign if_a.LoadStart = ls;   assign if_b.LoadStart = ls;
   assign if_a.LoadValid = lv;   assign if_b.LoadValid = lv;
   assign if_a.LoadLast  = ll;   assign if_b.LoadLast  = ll;
   assign if_a.LoadData  = ld;   assign if_b.LoadData  = ld;
   assign if_a.FetchReq  = fr;   assign if_b.FetchReq  = fr;
   assign if_a.InstAddress = addr;
   assign if_b.InstAddress = addr;

   inst_mem_loadable #(.INST_W(IW), .ADDR_W(AW), .DEPTH(256)) dut_a (
      .Clk(Clk), .ResetN(ResetN), .bus(if_a)
   );
   inst_mem_loadable #(.INST_W(IW), .ADDR_W(AW), .DEPTH(4)) dut_b (
      .Clk(Clk), .ResetN(ResetN), .bus(if_b)
   );

   // Reference model: state 0 = empty, 1 = loading, 2 = ready
   int            dep [2] = '{256, 4};
   int            m_state [2];
   int            m_len [2];
   logic          m_ovf [2];
   logic [IW-1:0] m_mem [2][256];
   logic [IW-1:0] m_out [2];
   exp_t          q_a [$];
   exp_t          q_b [$];
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d: got 0x%0h expected 0x%0h", nm, k, cyc, act, exp_v);
      end
   endtask

   function automatic int q_size(int k);
      return (k == 0) ? q_a.size() : q_b.size();
   endfunction

   function automatic exp_t q_front(int k);
      return (k == 0) ? q_a[0] : q_b[0];
   endfunction

   task automatic q_drop(int k);
      if (k == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0;
         m_len[k]   = 0;
         m_ovf[k]   = 1'b0;
         m_out[k]   = '0;
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_edge();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (m_state[k] == 0) begin
            if (ls) begin m_state[k] = 1; m_len[k] = 0; m_ovf[k] = 1'b0; end
         end else if (m_state[k] == 1) begin
            if (ls) begin
               m_len[k] = 0; m_ovf[k] = 1'b0;
            end else begin
               if (lv) begin
                  if (m_len[k] < dep[k]) begin
                     m_mem[k][m_len[k]] = ld;
                     m_len[k]++;
                  end else begin
                     m_ovf[k] = 1'b1;
                  end
               end
               if (ll) m_state[k] = 2;
            end
         end else begin
            if (ls) begin
               m_state[k] = 1; m_len[k] = 0; m_ovf[k] = 1'b0;
            end else if (fr) begin
               e.cyc = cyc;
               if (int'(addr) < m_len[k]) begin
                  e.data = m_mem[k][addr]; e.fault = 1'b0;
               end else begin
                  e.data = '0; e.fault = 1'b1;
               end
               if (k == 0) q_a.push_back(e);
               else        q_b.push_back(e);
            end
         end
      end
   endtask

   task automatic step(input logic s, input logic v, input logic l,
                       input logic [IW-1:0] d, input logic f, input logic [AW-1:0] a);
      ls = s; lv = v; ll = l; ld = d; fr = f; addr = a;
      @(posedge Clk);
      cyc++;
      model_edge();
      @(negedge Clk);
   endtask

   task automatic do_reset();
      #1;
      ResetN = 1'b0;
      #1;
      model_reset();
      @(negedge Clk);
      #1;
      ResetN = 1'b1;
   endtask

   task automatic mon(int k, logic v, logic [IW-1:0] o, logic f, logic busy,
                      logic rdy, logic [AW:0] len, logic ovf);
      exp_t e;
      chk("load_busy", k, 32'(busy), 32'(m_state[k] == 1));
      chk("ready", k, 32'(rdy), 32'(m_state[k] == 2));
      chk("prog_len", k, 32'(len), m_len[k]);
      chk("load_overflow", k, 32'(ovf), 32'(m_ovf[k]));
      if (v === 1'b1) begin
         if (q_size(k) == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid dut%0d cyc=%0d: got InstValid=1 expected 0", k, cyc);
         end else begin
            e = q_front(k);
            q_drop(k);
            chk("fetch_cycle", k, cyc, e.cyc);
            chk("inst_out", k, 32'(o), 32'(e.data));
            chk("addr_fault", k, 32'(f), 32'(e.fault));
            m_out[k] = e.data;
         end
      end else begin
         chk("inst_valid", k, 32'(v), 32'd0);
         chk("fault_idle", k, 32'(f), 32'd0);
         chk("inst_hold", k, 32'(o), 32'(m_out[k]));
         if (q_size(k) != 0 && int'(q_front(k).cyc) <= cyc) begin
            total++; bad++;
            $display("FAIL missing_valid dut%0d cyc=%0d: got InstValid=0 expected 1", k, cyc);
            q_drop(k);
         end
      end
   endtask

   always @(negedge Clk) begin
      mon(0, if_a.InstValid, if_a.InstOut, if_a.AddrFault, if_a.LoadBusy,
          if_a.Ready, if_a.ProgLen, if_a.LoadOverflow);
      mon(1, if_b.InstValid, if_b.InstOut, if_b.AddrFault, if_b.LoadBusy,
          if_b.Ready, if_b.ProgLen, if_b.LoadOverflow);
   end

   logic [IW-1:0] w [27];

   initial begin
      model_reset();
      repeat (2) @(negedge Clk);
      #1 ResetN = 1'b1;

      // Fetches in EMPTY are ignored
      repeat (3) step(0, 0, 0, '0, 1, 16'd0);

      // 27-word program; DEPTH 4 instance overflows on the same stream
      for (int i = 0; i < 27; i++) w[i] = IW'($urandom_range(0, 1023));
      w[0] = 10'h080; w[1] = 10'h212; w[26] = 10'h101;
      step(1, 0, 0, '0, 0, 16'd0);
      for (int i = 0; i < 27; i++) step(0, 1, (i == 26), w[i], (i % 3 == 0), AW'(i));

      step(0, 0, 0, '0, 1, 16'd0);
      step(0, 0, 0, '0, 1, 16'd1);
      step(0, 0, 0, '0, 1, 16'd26);
      step(0, 0, 0, '0, 1, 16'd27);
      step(0, 0, 0, '0, 1, 16'hFFFF);
      step(0, 0, 0, '0, 1, 16'd3);
      step(0, 0, 0, '0, 1, 16'd4);
      step(0, 0, 0, '0, 0, 16'd0);

      // LoadStart beats a same-cycle fetch
      step(1, 0, 0, '0, 1, 16'd0);

      // Reset part-way through a load
      for (int i = 0; i < 3; i++) step(0, 1, 0, IW'($urandom), 0, 16'd0);
      do_reset();
      step(0, 0, 0, '0, 0, 16'd0);
      step(1, 0, 0, '0, 0, 16'd0);
      step(0, 1, 0, 10'h155, 0, 16'd0);
      step(0, 1, 1, 10'h2AA, 0, 16'd0);
      step(0, 0, 0, '0, 1, 16'd2);
      step(0, 0, 0, '0, 1, 16'd0);
      step(0, 0, 0, '0, 1, 16'd1);

      // End marker with no word attached
      step(1, 0, 0, '0, 0, 16'd0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, IW'($urandom), 0, 16'd0);
      step(0, 0, 1, 10'h3FF, 0, 16'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, AW'(i));

      // Random mix of loads, restarts, fetches and resets
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] a;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 10));
            step(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 11) == 0),
                 IW'($urandom), 1'($urandom), a);
         end
      end

      repeat (3) step(0, 0, 0, '0, 0, 16'd0);
      chk("queue_drained", 0, q_a.size(), 0);
      chk("queue_drained", 1, q_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
